// File: rtl/vlogic_unit.sv
// Vector bitwise-logic lane: eight logic ops with per-element masking at SEW 8..64,
// a configurable-depth pipeline with ready/valid backpressure and address/tag sideband.
module vlogic_unit #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int OPSEL_WIDTH     = 3,
    parameter int LATENCY         = 6,
    parameter int MASK_ENABLE     = 1,
    parameter int VEC_MOVE_ENABLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_vec0,
    input  logic [DATA_WIDTH-1:0]   in_vec1,
    input  logic [DATA_WIDTH-1:0]   in_vd,
    input  logic [OPSEL_WIDTH-1:0]  in_opSel,
    input  logic [1:0]              in_sew,
    input  logic                    in_vm,
    input  logic [DATA_WIDTH/8-1:0] in_mask,
    input  logic                    in_sca,
    input  logic                    in_w_reg,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_vec,
    output logic                    out_valid,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic                    out_w_reg,
    output logic                    out_sca
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int LAST       = LATENCY - 1;

    logic adv;

    logic                   s0_valid;
    logic [DATA_WIDTH-1:0]  s0_a;
    logic [DATA_WIDTH-1:0]  s0_b;
    logic [DATA_WIDTH-1:0]  s0_vd;
    logic [OPSEL_WIDTH-1:0] s0_op;
    logic [1:0]             s0_sew;
    logic                   s0_vm;
    logic [MASK_WIDTH-1:0]  s0_mask;
    logic [ADDR_WIDTH-1:0]  s0_addr;
    logic                   s0_sca;
    logic                   s0_w_reg;

    logic [DATA_WIDTH-1:0]  op_res;
    logic [DATA_WIDTH-1:0]  elem_bit;
    logic [DATA_WIDTH-1:0]  act;
    logic [DATA_WIDTH-1:0]  masked_res;

    logic                   p_valid [1:LAST];
    logic [DATA_WIDTH-1:0]  p_data  [1:LAST];
    logic [ADDR_WIDTH-1:0]  p_addr  [1:LAST];
    logic                   p_sca   [1:LAST];
    logic                   p_w_reg [1:LAST];

    // The whole pipeline moves as one unit: it advances unless the output is stuck.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
            s0_vd    <= '0;
            s0_op    <= '0;
            s0_sew   <= '0;
            s0_vm    <= 1'b0;
            s0_mask  <= '0;
            s0_addr  <= '0;
            s0_sca   <= 1'b0;
            s0_w_reg <= 1'b0;
        end else if (adv) begin
            if (in_valid) begin
                s0_valid <= 1'b1;
                s0_a     <= in_vec0;
                s0_b     <= in_vec1;
                s0_vd    <= in_vd;
                s0_op    <= in_opSel;
                s0_sew   <= in_sew;
                s0_vm    <= in_vm;
                s0_mask  <= in_mask;
                s0_addr  <= in_addr;
                s0_sca   <= in_sca & (VEC_MOVE_ENABLE != 0);
                s0_w_reg <= in_w_reg & (VEC_MOVE_ENABLE != 0);
            end else begin
                s0_valid <= 1'b0;
                s0_a     <= '0;
                s0_b     <= '0;
                s0_vd    <= '0;
                s0_op    <= '0;
                s0_sew   <= '0;
                s0_vm    <= 1'b0;
                s0_mask  <= '0;
                s0_addr  <= '0;
                s0_sca   <= 1'b0;
                s0_w_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        case (s0_op)
            3'd0:    op_res = s0_a;
            3'd1:    op_res = s0_a & s0_b;
            3'd2:    op_res = s0_a | s0_b;
            3'd3:    op_res = s0_a ^ s0_b;
            3'd4:    op_res = s0_a & ~s0_b;
            3'd5:    op_res = ~(s0_a & s0_b);
            3'd6:    op_res = ~(s0_a | s0_b);
            3'd7:    op_res = ~(s0_a ^ s0_b);
            default: op_res = s0_a;
        endcase
    end

    // Each data bit picks the mask bit of the element it belongs to at the current SEW.
    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_elem
        assign elem_bit[g] = (s0_sew == 2'b00) ? s0_mask[g/8]  :
                             (s0_sew == 2'b01) ? s0_mask[g/16] :
                             (s0_sew == 2'b10) ? s0_mask[g/32] :
                                                 s0_mask[g/64];
    end

    assign act        = ((MASK_ENABLE == 0) || s0_vm) ? {DATA_WIDTH{1'b1}} : elem_bit;
    assign masked_res = (op_res & act) | (s0_vd & ~act);

    // Bubbles enter stage 1 as zeros so negated ops on empty slots never show up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= LAST; k++) begin
                p_valid[k] <= 1'b0;
                p_data[k]  <= '0;
                p_addr[k]  <= '0;
                p_sca[k]   <= 1'b0;
                p_w_reg[k] <= 1'b0;
            end
        end else if (adv) begin
            p_valid[1] <= s0_valid;
            p_data[1]  <= s0_valid ? masked_res : '0;
            p_addr[1]  <= s0_addr;
            p_sca[1]   <= s0_sca;
            p_w_reg[1] <= s0_w_reg;
            for (int k = 2; k <= LAST; k++) begin
                p_valid[k] <= p_valid[k-1];
                p_data[k]  <= p_data[k-1];
                p_addr[k]  <= p_addr[k-1];
                p_sca[k]   <= p_sca[k-1];
                p_w_reg[k] <= p_w_reg[k-1];
            end
        end
    end

    assign out_valid = p_valid[LAST];
    assign out_vec   = p_data[LAST];
    assign out_addr  = p_addr[LAST];
    assign out_sca   = p_sca[LAST];
    assign out_w_reg = p_w_reg[LAST];

endmodule

// File: tb/tb_vlogic_unit.sv
// Bench for vlogic_unit: a default 64-bit/LATENCY=6 instance and a 128-bit/LATENCY=2
// instance share one stimulus stream; a queue model with due cycles checks both every cycle.
module tb_vlogic_unit;

    localparam logic [63:0] VA = 64'hF0F0_F0F0_F0F0_F0F0;
    localparam logic [63:0] VB = 64'hFF00_FF00_FF00_FF00;
    localparam logic [63:0] VD = 64'h1122_3344_5566_7788;

    typedef struct {
        logic [127:0] vec;
        logic [31:0]  addr;
        logic         sca;
        logic         wreg;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid, out_ready, in_vm, in_sca, in_w_reg;
    logic [31:0]  in_addr;
    logic [127:0] in_vec0, in_vec1, in_vd;
    logic [2:0]   in_opSel;
    logic [1:0]   in_sew;
    logic [15:0]  in_mask;

    logic         a_in_ready, a_out_valid, a_out_w_reg, a_out_sca;
    logic [63:0]  a_out_vec;
    logic [31:0]  a_out_addr;
    logic         b_in_ready, b_out_valid, b_out_w_reg, b_out_sca;
    logic [127:0] b_out_vec;
    logic [31:0]  b_out_addr;

    int   checks = 0;
    int   errors = 0;
    int   cyc_a = 0;
    int   cyc_b = 0;
    int   stall_cnt = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t log_a[$];

    always #5 clk = ~clk;

    vlogic_unit dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_addr(in_addr), .in_vec0(in_vec0[63:0]), .in_vec1(in_vec1[63:0]), .in_vd(in_vd[63:0]),
        .in_opSel(in_opSel), .in_sew(in_sew), .in_vm(in_vm), .in_mask(in_mask[7:0]),
        .in_sca(in_sca), .in_w_reg(in_w_reg), .out_ready(out_ready), .out_vec(a_out_vec),
        .out_valid(a_out_valid), .out_addr(a_out_addr), .out_w_reg(a_out_w_reg), .out_sca(a_out_sca)
    );

    vlogic_unit #(.DATA_WIDTH(128), .LATENCY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_addr(in_addr), .in_vec0(in_vec0), .in_vec1(in_vec1), .in_vd(in_vd),
        .in_opSel(in_opSel), .in_sew(in_sew), .in_vm(in_vm), .in_mask(in_mask),
        .in_sca(in_sca), .in_w_reg(in_w_reg), .out_ready(out_ready), .out_vec(b_out_vec),
        .out_valid(b_out_valid), .out_addr(b_out_addr), .out_w_reg(b_out_w_reg), .out_sca(b_out_sca)
    );

    // Expected result from the op table and element-wise masking, w bits wide.
    function automatic logic [127:0] model_vec(input int w, input logic [2:0] op,
                                               input logic [127:0] a, input logic [127:0] b,
                                               input logic [127:0] vd, input logic [1:0] sew,
                                               input logic vm, input logic [15:0] mask);
        logic [127:0] r;
        logic [127:0] res;
        int e;
        case (op)
            3'd0: r = a;
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3: r = a ^ b;
            3'd4: r = a & ~b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = ~(a ^ b);
        endcase
        e = 8 << sew;
        res = '0;
        for (int j = 0; j < w; j++)
            res[j] = (vm || mask[j/e]) ? r[j] : vd[j];
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model A: each accepted beat is due LATENCY edges later, pushed back one per stalled cycle.
    always @(posedge clk or negedge rst_n) begin
        logic ev;
        if (!rst_n) begin
            qa.delete();
        end else begin
            ev = (qa.size() > 0) && (qa[0].due == cyc_a);
            if (ev && !out_ready) begin
                foreach (qa[i]) qa[i].due++;
            end else if (ev) begin
                void'(qa.pop_front());
            end
            if (in_valid && (out_ready || !ev))
                qa.push_back('{model_vec(64, in_opSel, in_vec0, in_vec1, in_vd, in_sew, in_vm, in_mask),
                               in_addr, in_sca, in_w_reg, cyc_a + 6});
            cyc_a++;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        logic ev;
        if (!rst_n) begin
            qb.delete();
        end else begin
            ev = (qb.size() > 0) && (qb[0].due == cyc_b);
            if (ev && !out_ready) begin
                foreach (qb[i]) qb[i].due++;
            end else if (ev) begin
                void'(qb.pop_front());
            end
            if (in_valid && (out_ready || !ev))
                qb.push_back('{model_vec(128, in_opSel, in_vec0, in_vec1, in_vd, in_sew, in_vm, in_mask),
                               in_addr, in_sca, in_w_reg, cyc_b + 2});
            cyc_b++;
        end
    end

    // Per-cycle comparison of both instances against the models.
    always @(negedge clk) begin
        logic eva, evb;
        if (!rst_n) begin
            checkOutput("rst_A_valid", a_out_valid, 0);
            checkOutput("rst_A_vec", a_out_vec, 0);
            checkOutput("rst_A_ready", a_in_ready, 1);
            checkOutput("rst_B_valid", b_out_valid, 0);
        end else begin
            eva = (qa.size() > 0) && (qa[0].due == cyc_a);
            evb = (qb.size() > 0) && (qb[0].due == cyc_b);
            checkOutput("A_valid", a_out_valid, eva);
            checkOutput("A_vec", a_out_vec, eva ? qa[0].vec[63:0] : 64'd0);
            checkOutput("A_addr", a_out_addr, eva ? qa[0].addr : 32'd0);
            checkOutput("A_sca", a_out_sca, eva ? qa[0].sca : 1'b0);
            checkOutput("A_wreg", a_out_w_reg, eva ? qa[0].wreg : 1'b0);
            checkOutput("A_in_ready", a_in_ready, out_ready || !eva);
            checkOutput("B_valid", b_out_valid, evb);
            checkOutput("B_vec", b_out_vec, evb ? qb[0].vec : 128'd0);
            checkOutput("B_addr", b_out_addr, evb ? qb[0].addr : 32'd0);
            checkOutput("B_sca", b_out_sca, evb ? qb[0].sca : 1'b0);
            checkOutput("B_wreg", b_out_w_reg, evb ? qb[0].wreg : 1'b0);
            checkOutput("B_in_ready", b_in_ready, out_ready || !evb);
            if (a_out_valid && out_ready)
                log_a.push_back('{{64'd0, a_out_vec}, a_out_addr, a_out_sca, a_out_w_reg, cyc_a});
            if (a_out_valid && !a_in_ready)
                stall_cnt++;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] addr, input logic [127:0] a,
                                 input logic [127:0] b, input logic [127:0] vd, input logic [2:0] op,
                                 input logic [1:0] sew, input logic vm, input logic [15:0] mask,
                                 input logic sca, input logic wreg);
        in_valid = v;  in_addr = addr;  in_vec0 = a;  in_vec1 = b;  in_vd = vd;
        in_opSel = op; in_sew = sew;    in_vm = vm;   in_mask = mask;
        in_sca = sca;  in_w_reg = wreg;
    endtask

    task automatic idle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic waitValidA(input int limit);
        int n = 0;
        while (!a_out_valid && n < limit) begin
            step;
            n++;
        end
        checkOutput("wait_A_valid", a_out_valid, 1);
    endtask

    initial begin
        logic [63:0] exp2 [8];
        exp2 = '{VA, 64'hF000_F000_F000_F000, 64'hFFF0_FFF0_FFF0_FFF0, 64'h0FF0_0FF0_0FF0_0FF0,
                 64'h00F0_00F0_00F0_00F0, 64'h0FFF_0FFF_0FFF_0FFF, 64'h000F_000F_000F_000F,
                 64'hF00F_F00F_F00F_F00F};
        out_ready = 1'b1;
        idle;
        #1 rst_n = 1'b0;

        // Reset state while held and after release.
        repeat (3) step;
        checkOutput("T1_rst_vec", a_out_vec, 0);
        checkOutput("T1_rst_ready", a_in_ready, 1);
        rst_n = 1'b1;
        step;
        checkOutput("T1_rel_valid", a_out_valid, 0);
        checkOutput("T1_rel_addr", a_out_addr, 0);

        // Test 1: single AND beat, latency 6 on A and 2 on B.
        applyStimulus(1, 32'h10, {VA, VA}, {VB, VB}, 0, 3'b001, 2'b00, 1, 0, 0, 0);
        step;
        idle;
        for (int i = 2; i <= 7; i++) begin
            step;
            if (i == 2) begin
                checkOutput("T1_B_valid", b_out_valid, 1);
                checkOutput("T1_B_vec", b_out_vec, {2{64'hF000_F000_F000_F000}});
            end
            if (i == 3) checkOutput("T1_B_valid_gone", b_out_valid, 0);
            if (i == 5) checkOutput("T1_A_early", a_out_valid, 0);
            if (i == 6) begin
                checkOutput("T1_A_valid", a_out_valid, 1);
                checkOutput("T1_A_vec", a_out_vec, 64'hF000_F000_F000_F000);
            end
            if (i == 7) checkOutput("T1_A_one_cycle", a_out_valid, 0);
        end
        repeat (3) step;

        // Test 2: all opcodes back to back.
        log_a.delete();
        for (int op = 0; op < 8; op++) begin
            applyStimulus(1, 32'(op), {VA, VA}, {VB, VB}, 0, 3'(op), 2'b00, 1, 0, 0, 0);
            step;
        end
        idle;
        repeat (10) step;
        checkOutput("T2_count", log_a.size(), 8);
        for (int i = 0; i < 8 && i < log_a.size(); i++) begin
            checkOutput($sformatf("T2_op%0d", i), log_a[i].vec, {64'd0, exp2[i]});
            if (i > 0) checkOutput($sformatf("T2_consec%0d", i), log_a[i].due - log_a[i-1].due, 1);
        end

        // Test 3: masking at SEW 8, 32 and 64 (mask bits past the element count ignored).
        log_a.delete();
        applyStimulus(1, 32'h31, '1, '1, {VD, VD}, 3'b011, 2'b00, 0, 16'h5555, 0, 0);
        step;
        applyStimulus(1, 32'h32, '1, 0, {VD, VD}, 3'b000, 2'b10, 0, 16'h0002, 0, 0);
        step;
        applyStimulus(1, 32'h33, '1, 0, {VD, VD}, 3'b000, 2'b11, 0, 16'hFEFE, 0, 0);
        step;
        idle;
        repeat (10) step;
        checkOutput("T3_count", log_a.size(), 3);
        if (log_a.size() == 3) begin
            checkOutput("T3_sew8", log_a[0].vec, 64'h1100_3300_5500_7700);
            checkOutput("T3_sew32", log_a[1].vec, 64'hFFFF_FFFF_5566_7788);
            checkOutput("T3_sew64_hi_ignored", log_a[2].vec, VD);
        end

        // Test 4: ten beats with a three-cycle output stall after the first result.
        log_a.delete();
        stall_cnt = 0;
        fork
            begin
                for (int k = 1; k <= 10; k++) begin
                    logic acc;
                    int tries;
                    tries = 0;
                    applyStimulus(1, 32'(k), {2{64'(k) * 64'h0101_0101_0101_0101}}, {VB, VB}, 0,
                                  3'b010, 2'b00, 1, 0, 0, 0);
                    do begin
                        #1;
                        acc = a_in_ready;
                        step;
                        tries++;
                    end while (!acc && tries < 20);
                    if (!acc) checkOutput("T4_accept_timeout", acc, 1);
                end
                idle;
            end
            begin
                waitValidA(20);
                step;
                out_ready = 1'b0;
                repeat (3) step;
                out_ready = 1'b1;
            end
        join
        repeat (15) step;
        checkOutput("T4_count", log_a.size(), 10);
        checkOutput("T4_stall_cycles", stall_cnt, 3);
        for (int i = 0; i < 10 && i < log_a.size(); i++)
            checkOutput($sformatf("T4_addr%0d", i + 1), log_a[i].addr, 32'(i + 1));

        // Test 5: asynchronous reset between edges with beats in flight.
        log_a.delete();
        for (int k = 21; k <= 23; k++) begin
            applyStimulus(1, 32'(k), {VA, VA}, {VB, VB}, 0, 3'b011, 2'b00, 1, 0, 1, 1);
            step;
        end
        idle;
        waitValidA(20);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("T5_async_valid", a_out_valid, 0);
        checkOutput("T5_async_vec", a_out_vec, 0);
        checkOutput("T5_async_addr", a_out_addr, 0);
        checkOutput("T5_async_sca", a_out_sca, 0);
        checkOutput("T5_async_ready", a_in_ready, 1);
        repeat (2) step;
        rst_n = 1'b1;
        repeat (12) step;
        checkOutput("T5_no_ghost", log_a.size(), 0);

        // Test 6: sca tag on the second beat only, then w_reg through the short pipeline.
        log_a.delete();
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1, 32'(30 + k), {VA, VA}, {VB, VB}, 0, 3'b001, 2'b00, 1, 0, (k == 2), 0);
            step;
        end
        idle;
        repeat (10) step;
        checkOutput("T6_count", log_a.size(), 3);
        if (log_a.size() == 3) begin
            checkOutput("T6_sca_b1", log_a[0].sca, 0);
            checkOutput("T6_sca_b2", log_a[1].sca, 1);
            checkOutput("T6_sca_b3", log_a[2].sca, 0);
        end
        applyStimulus(1, 32'h40, {VA, VA}, {VB, VB}, 0, 3'b001, 2'b00, 1, 0, 0, 1);
        step;
        idle;
        checkOutput("T6_wreg_early", b_out_w_reg, 0);
        step;
        checkOutput("T6_wreg", b_out_w_reg, 1);
        checkOutput("T6_wreg_addr", b_out_addr, 32'h40);
        step;
        checkOutput("T6_wreg_gone", b_out_w_reg, 0);
        repeat (8) step;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
